demux4x16_stream: RTL and testbench

//  Inverse of the 4:1 16b operand select: routes one 16b input stream to one of four
//  16b output channels, chosen by a 2b select sampled with each word. Each channel has
//  its own FIFO, so a stalled consumer holds back only traffic aimed at it.

---
 rtl/demux4x16_stream.sv | 139 +++++++++++++
 tb/tb_demux4x16_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4x16_stream.sv
// demux4x16_stream: 1-to-4 stream demux, per-channel FIFO; optional broadcast via `ifdef DEMUX_BCAST_EN.
// Latency 1 cycle from accept to o<k>/out_valid[k]; no same-cycle bypass.
// Backpressure: in_ready drops only while the addressed FIFO (any FIFO when broadcasting) is full.

// demux4x16_fifo: DEPTH-entry synchronous FIFO, head word always visible on o_dat.
// Latency 1 cycle push to o_vld; pop on i_pop while non-empty.
// Backpressure: o_full from registered occupancy; pushes while full are dropped.
module demux4x16_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dat,
    output logic                   o_vld,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_occ
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             w_push;
    logic             w_pop;

    // out_ready on an empty channel must not move the read pointer
    assign w_pop  = i_pop && (r_occ != '0);
    assign w_push = i_push && !o_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_ONE;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_ONE;
            end
        end
    end

    assign o_dat  = r_mem[r_rd_ptr];
    assign o_vld  = (r_occ != '0);
    assign o_full = (r_occ == OCC_FULL);
    assign o_occ  = r_occ;
endmodule

// demux4x16_stream: routes in_data to channel in_sel (or all channels on in_bcast).
// Latency 1 cycle accept to output; each channel drains independently.
// Backpressure: per-channel FIFOs, so a stalled consumer only blocks words aimed at it.
module demux4x16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic                   in_bcast,
`endif
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [WIDTH-1:0]       o0,
    output logic [WIDTH-1:0]       o1,
    output logic [WIDTH-1:0]       o2,
    output logic [WIDTH-1:0]       o3,
    output logic [$clog2(DEPTH):0] occ0,
    output logic [$clog2(DEPTH):0] occ1,
    output logic [$clog2(DEPTH):0] occ2,
    output logic [$clog2(DEPTH):0] occ3
);
    logic [3:0]             w_full;
    logic [3:0]             w_push;
    logic                   w_accept;
    logic                   w_bcast;
    logic [WIDTH-1:0]       w_dat [4];
    logic [$clog2(DEPTH):0] w_occ [4];

`ifdef DEMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Registered full flags only: no path from out_ready to in_ready
    assign in_ready = w_bcast ? ~(|w_full) : ~w_full[in_sel];
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign w_push[k] = w_accept && (w_bcast || (in_sel == 2'(k)));

        demux4x16_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .i_push (w_push[k]),
            .i_dat  (in_data),
            .i_pop  (out_ready[k]),
            .o_dat  (w_dat[k]),
            .o_vld  (out_valid[k]),
            .o_full (w_full[k]),
            .o_occ  (w_occ[k])
        );
    end

    assign o0   = w_dat[0];
    assign o1   = w_dat[1];
    assign o2   = w_dat[2];
    assign o3   = w_dat[3];
    assign occ0 = w_occ[0];
    assign occ1 = w_occ[1];
    assign occ2 = w_occ[2];
    assign occ3 = w_occ[3];
endmodule

// File: tb/tb_demux4x16_stream.sv
// Bench for demux4x16_stream: queue-based model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_demux4x16_stream;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH) + 1;
`ifdef DEMUX_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct {
        int          ch;
        logic [15:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bcast = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = '0;
    logic [1:0]    in_sel = '0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = '0;
    logic [15:0]   o0, o1, o2, o3;
    logic [OW-1:0] occ0, occ1, occ2, occ3;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];    // every queued word in acceptance order, tagged with its channel
    ent_t elog[$];  // words actually handed to consumers

    demux4x16_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .occ0      (occ0),
        .occ1      (occ1),
        .occ2      (occ2),
        .occ3      (occ3)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_cnt(input int k);
        int n = 0;
        for (int i = 0; i < mq.size(); i++) if (mq[i].ch == k) n++;
        return n;
    endfunction

    function automatic logic [15:0] m_head(input int k);
        for (int i = 0; i < mq.size(); i++) if (mq[i].ch == k) return mq[i].d;
        return '0;
    endfunction

    function automatic void m_pop(input int k);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].ch == k) begin
                mq.delete(i);
                return;
            end
        end
    endfunction

    function automatic logic m_ready();
        if (BCAST && in_bcast)
            return (m_cnt(0) < DEPTH) && (m_cnt(1) < DEPTH) && (m_cnt(2) < DEPTH) && (m_cnt(3) < DEPTH);
        return m_cnt(int'(in_sel)) < DEPTH;
    endfunction

    function automatic logic [15:0] dout(input int k);
        case (k)
            0: return o0;
            1: return o1;
            2: return o2;
            default: return o3;
        endcase
    endfunction

    function automatic logic [31:0] docc(input int k);
        case (k)
            0: return 32'(occ0);
            1: return 32'(occ1);
            2: return 32'(occ2);
            default: return 32'(occ3);
        endcase
    endfunction

    // Model: decisions from the pre-edge state, then pops, then pushes
    always @(posedge clk) begin : mdl
        logic       acc;
        logic [3:0] pop;
        ent_t       e;
        if (!reset) begin
            acc = in_valid && m_ready();
            for (int k = 0; k < 4; k++) pop[k] = out_ready[k] && (m_cnt(k) > 0);
            for (int k = 0; k < 4; k++) if (pop[k]) m_pop(k);
            if (acc) begin
                e.d = in_data;
                if (BCAST && in_bcast) begin
                    for (int k = 0; k < 4; k++) begin
                        e.ch = k;
                        mq.push_back(e);
                    end
                end else begin
                    e.ch = int'(in_sel);
                    mq.push_back(e);
                end
            end
        end
    end

    always @(posedge reset) mq.delete();

    always @(negedge clk) begin : cmp
        ent_t e;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_cnt(k) != 0));
            check($sformatf("occ%0d", k), docc(k), 32'(m_cnt(k)));
            if (m_cnt(k) != 0) check($sformatf("o%0d head", k), 32'(dout(k)), 32'(m_head(k)));
            if (out_valid[k] && out_ready[k]) begin
                e.ch = k;
                e.d  = dout(k);
                elog.push_back(e);
            end
        end
        check("in_ready", 32'(in_ready), 32'(m_ready()));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: nothing accepted while asserted, in_ready evaluates to 1
        #1 reset = 1'b1;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hDEAD;
        #1 check("rst in_ready", 32'(in_ready), 32'd1);
        step(); step();
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst occ0", 32'(occ0), 32'd0);
        in_valid = 1'b0; reset = 1'b0;
        step();

        // T2 unicast to ch2
        in_valid = 1'b1; in_data = 16'h3C00; in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        check("T2 out_valid", 32'(out_valid), 32'b0100);
        check("T2 o2", 32'(o2), 32'h3C00);
        check("T2 occ2", 32'(occ2), 32'd1);
        out_ready = 4'b0100; step(); out_ready = '0;
        check("T2 drained", 32'(out_valid), 32'h0);

        // T3 fill ch0, backpressure is per channel
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h0001; step();
        in_data = 16'h0002; step();
        in_valid = 1'b0;
        check("T3 occ0", 32'(occ0), 32'd2);
        check("T3 o0 first", 32'(o0), 32'h0001);
        #1 check("T3 in_ready sel0", 32'(in_ready), 32'd0);
        in_sel = 2'd1;
        #1 check("T3 in_ready sel1", 32'(in_ready), 32'd1);
        out_ready = 4'b0001; step(); out_ready = '0;
        check("T3 o0 second", 32'(o0), 32'h0002);
        check("T3 occ0 after pop", 32'(occ0), 32'd1);
        out_ready = 4'b0001; step(); out_ready = '0;
        check("T3 drained", 32'(out_valid), 32'h0);

        // T4 push+pop on full ch3: push refused, retry accepted
        in_valid = 1'b1; in_sel = 2'd3; in_data = 16'h0031; step();
        in_data = 16'h0032; step();
        in_data = 16'h0033; out_ready = 4'b1000;
        #1 check("T4 in_ready full", 32'(in_ready), 32'd0);
        step(); out_ready = '0;
        check("T4 occ3 refused", 32'(occ3), 32'd1);
        check("T4 o3", 32'(o3), 32'h0032);
        step(); in_valid = 1'b0;
        check("T4 occ3 retry", 32'(occ3), 32'd2);
        out_ready = 4'b1000; step();
        check("T4 o3 retried word", 32'(o3), 32'h0033);
        step(); out_ready = '0;
        check("T4 drained", 32'(out_valid), 32'h0);

        // T5 interleave A,B,C to ch1,ch0,ch1 with all consumers ready
        elog.delete();
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h00A1; step();
        in_sel = 2'd0; in_data = 16'h00B0; step();
        in_sel = 2'd1; in_data = 16'h00C1; step();
        in_valid = 1'b0;
        step(); step();
        check("T5 emitted count", 32'(elog.size()), 32'd3);
        if (elog.size() == 3) begin
            check("T5 e0 ch", 32'(elog[0].ch), 32'd1);
            check("T5 e0 data", 32'(elog[0].d), 32'h00A1);
            check("T5 e1 ch", 32'(elog[1].ch), 32'd0);
            check("T5 e1 data", 32'(elog[1].d), 32'h00B0);
            check("T5 e2 ch", 32'(elog[2].ch), 32'd1);
            check("T5 e2 data", 32'(elog[2].d), 32'h00C1);
        end
        out_ready = '0;

        // T1 reset mid-traffic with two words on ch1
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h1111; step();
        in_data = 16'h2222; step();
        in_valid = 1'b0;
        check("T1 occ1 before", 32'(occ1), 32'd2);
        #1 reset = 1'b1;
        #1 check("T1 out_valid", 32'(out_valid), 32'h0);
        check("T1 occ1", 32'(occ1), 32'd0);
        check("T1 o1", 32'(o1), 32'h0);
        elog.delete();
        step(); reset = 1'b0;
        out_ready = 4'b1111;
        step(); step(); step();
        check("T1 nothing emitted", 32'(elog.size()), 32'd0);
        check("T1 out_valid after", 32'(out_valid), 32'h0);
        out_ready = '0;

`ifdef DEMUX_BCAST_EN
        // T6 broadcast blocked by full ch2, then accepted into all four
        in_valid = 1'b1; in_sel = 2'd2; in_data = 16'h0201; step();
        in_data = 16'h0202; step();
        in_bcast = 1'b1; in_data = 16'hBEEF; in_sel = 2'd0;
        #1 check("T6 in_ready blocked", 32'(in_ready), 32'd0);
        out_ready = 4'b0100; step(); out_ready = '0;
        check("T6 occ2", 32'(occ2), 32'd1);
        check("T6 o2", 32'(o2), 32'h0202);
        check("T6 not accepted", 32'(out_valid), 32'b0100);
        #1 check("T6 in_ready open", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0; in_bcast = 1'b0;
        check("T6 out_valid", 32'(out_valid), 32'hF);
        check("T6 o0", 32'(o0), 32'hBEEF);
        check("T6 o1", 32'(o1), 32'hBEEF);
        check("T6 o3", 32'(o3), 32'hBEEF);
        check("T6 occ2 full", 32'(occ2), 32'd2);
        out_ready = 4'b0100; step(); out_ready = '0;
        check("T6 o2", 32'(o2), 32'hBEEF);
        out_ready = 4'b1111; step(); step(); out_ready = '0;
        check("T6 drained", 32'(out_valid), 32'h0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
